// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module : eth_pkg
// Shared Ethernet receive constants, FSM encoding and byte-wide CRC-32 step.
// Rev    : 1.0
// ============================================================================
package eth_pkg;

  localparam logic [7:0]  c_SFD         = 8'hD5;
  localparam logic [31:0] c_CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] c_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          c_MIN_LEN     = 64;
  localparam int          c_MAX_LEN     = 1518;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_DROP     = 3'd3,
    ST_END      = 3'd4
  } rx_state_t;

  // Ethernet bit order is LSB first, so the register runs in reflected form.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crcIn,
                                             input logic [7:0]  data);
    logic [31:0] w_reg;
    logic [31:0] w_polyRefl;
    for (int i = 0; i < 32; i++) w_polyRefl[i] = c_CRC_POLY[31-i];
    w_reg = crcIn ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      w_reg = w_reg[0] ? ((w_reg >> 1) ^ w_polyRefl) : (w_reg >> 1);
    return w_reg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc_gen.sv
`default_nettype none
// ============================================================================
// Module : eth_crc_gen
// Byte-wide CRC-32 accumulator; held at the init value while Crc_Req is low.
// Rev    : 1.0
// ============================================================================
module eth_crc_gen
  import eth_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Crc_Req,
  input  logic        Byte_Stb,
  input  logic [7:0]  Byte_Data,
  output logic [31:0] Crc
);

  always_ff @(posedge Clk) begin
    if (!Rst || !Crc_Req)
      Crc <= c_CRC_INIT;
    else if (Byte_Stb)
      Crc <= crc32_byte(Crc, Byte_Data);
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_stream.sv
`default_nettype none
// ============================================================================
// Module : eth_rx_stream
// RMII/MII receive front end: SFD hunt, byte assembly, byte stream, frame status.
// Rev    : 1.0
// ============================================================================
module eth_rx_stream
  import eth_pkg::*;
#(
  parameter int pDATA_WIDTH = 2,
  parameter int pSTRIP_FCS  = 1,
  parameter int pMIN_LEN    = c_MIN_LEN,
  parameter int pMAX_LEN    = c_MAX_LEN,
  parameter int pLEN_W      = 11
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Crs_Dv,
  input  logic [pDATA_WIDTH-1:0] Rxd,
  output logic                   Rx_Valid,
  output logic [7:0]             Rx_Data,
  output logic                   Rx_Sof,
  output logic                   Frame_Done,
  output logic                   Frame_Good,
  output logic                   Crc_Err,
  output logic                   Align_Err,
  output logic                   Len_Err,
  output logic [pLEN_W-1:0]      Frame_Len
);

  localparam logic [1:0]        c_LAST_BEAT = 2'(8 / pDATA_WIDTH - 1);
  localparam logic [pLEN_W-1:0] c_MIN       = pLEN_W'(pMIN_LEN);
  localparam logic [pLEN_W-1:0] c_MAX       = pLEN_W'(pMAX_LEN);
  localparam logic [pLEN_W-1:0] c_MAX_P1    = pLEN_W'(pMAX_LEN + 1);

  rx_state_t         r_state, w_nextState;
  logic              r_armed;
  logic [7:0]        r_shift, w_shiftNext;
  logic [1:0]        r_bitCnt;
  logic [pLEN_W-1:0] r_byteCnt, w_cntNext;
  logic              w_inFrame, w_byteDone, w_overMax, w_lenErr;
  logic              r_crcStb;
  logic [7:0]        r_crcByte;
  logic [31:0]       w_crc;
  logic              r_sofPend, r_alignErr, r_crcErr, r_endWait;
  logic              w_outValid;
  logic [7:0]        w_outByte;

  assign w_shiftNext = {Rxd, r_shift[7:pDATA_WIDTH]};
  assign w_inFrame   = (r_state == ST_DATA) || (r_state == ST_DROP);
  assign w_byteDone  = w_inFrame && Crs_Dv && (r_bitCnt == c_LAST_BEAT);
  assign w_cntNext   = (r_byteCnt == '1) ? r_byteCnt : r_byteCnt + 1'b1;
  assign w_overMax   = w_byteDone && (r_state == ST_DATA) && (w_cntNext == c_MAX_P1);
  assign w_lenErr    = (r_byteCnt < c_MIN) || (r_byteCnt > c_MAX);

  if (pSTRIP_FCS != 0) begin : g_strip
    // Four-byte delay line: a byte leaves only once four later bytes exist,
    // so the trailing FCS never reaches the output.
    logic [31:0] r_dly;
    always_ff @(posedge Clk) begin
      if (!Rst)
        r_dly <= '0;
      else if (w_byteDone)
        r_dly <= {r_dly[23:0], w_shiftNext};
    end
    assign w_outValid = w_byteDone && (r_state == ST_DATA) && !w_overMax &&
                        (r_byteCnt >= pLEN_W'(4));
    assign w_outByte  = r_dly[31:24];
  end else begin : g_pass
    assign w_outValid = w_byteDone && (r_state == ST_DATA) && !w_overMax;
    assign w_outByte  = w_shiftNext;
  end

  always_ff @(posedge Clk) begin
    if (!Rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:     if (r_armed && Crs_Dv) w_nextState = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!Crs_Dv)                    w_nextState = ST_IDLE;
        else if (w_shiftNext == c_SFD)  w_nextState = ST_DATA;
      end
      ST_DATA: begin
        if (!Crs_Dv)                    w_nextState = ST_END;
        else if (w_overMax)             w_nextState = ST_DROP;
      end
      ST_DROP:     if (!Crs_Dv) w_nextState = ST_END;
      ST_END:      if (r_endWait) w_nextState = ST_IDLE;
      default:     w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_armed    <= 1'b0;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_byteCnt  <= '0;
      r_crcStb   <= 1'b0;
      r_crcByte  <= '0;
      r_sofPend  <= 1'b0;
      r_alignErr <= 1'b0;
      r_crcErr   <= 1'b0;
      r_endWait  <= 1'b0;
      Rx_Valid   <= 1'b0;
      Rx_Data    <= '0;
      Rx_Sof     <= 1'b0;
      Frame_Done <= 1'b0;
      Frame_Good <= 1'b0;
      Crc_Err    <= 1'b0;
      Align_Err  <= 1'b0;
      Len_Err    <= 1'b0;
      Frame_Len  <= '0;
    end else begin
      Rx_Valid   <= w_outValid;
      Rx_Data    <= w_outValid ? w_outByte : 8'h00;
      Rx_Sof     <= w_outValid && r_sofPend;
      if (w_outValid) r_sofPend <= 1'b0;
      r_crcStb   <= w_byteDone;
      if (w_byteDone) r_crcByte <= w_shiftNext;
      Frame_Done <= 1'b0;
      Frame_Good <= 1'b0;
      Crc_Err    <= 1'b0;
      Align_Err  <= 1'b0;
      Len_Err    <= 1'b0;
      Frame_Len  <= '0;

      case (r_state)
        ST_IDLE: begin
          r_endWait <= 1'b0;
          r_shift   <= Crs_Dv ? w_shiftNext : 8'h00;
          if (!Crs_Dv) r_armed <= 1'b1;
        end
        ST_PREAMBLE: begin
          if (Crs_Dv) begin
            r_shift <= w_shiftNext;
            if (w_shiftNext == c_SFD) begin
              r_bitCnt   <= '0;
              r_byteCnt  <= '0;
              r_sofPend  <= 1'b1;
              r_alignErr <= 1'b0;
            end
          end
        end
        ST_DATA, ST_DROP: begin
          r_endWait <= 1'b0;
          if (Crs_Dv) begin
            r_shift  <= w_shiftNext;
            r_bitCnt <= (r_bitCnt == c_LAST_BEAT) ? 2'd0 : r_bitCnt + 2'd1;
            if (w_byteDone) r_byteCnt <= w_cntNext;
          end else if (r_state == ST_DATA) begin
            r_alignErr <= (r_bitCnt != 2'd0);
          end
        end
        ST_END: begin
          // First END cycle samples the CRC after its last update; second reports.
          r_endWait <= 1'b1;
          if (!r_endWait) begin
            r_crcErr <= (w_crc != c_CRC_RESIDUE);
          end else begin
            Frame_Done <= 1'b1;
            Crc_Err    <= r_crcErr;
            Align_Err  <= r_alignErr;
            Len_Err    <= w_lenErr;
            Frame_Good <= !(r_crcErr || r_alignErr || w_lenErr);
            Frame_Len  <= r_byteCnt;
          end
        end
        default: r_endWait <= 1'b0;
      endcase
    end
  end

  eth_crc_gen u_crc (
    .Clk       (Clk),
    .Rst       (Rst),
    .Crc_Req   (w_inFrame),
    .Byte_Stb  (r_crcStb),
    .Byte_Data (r_crcByte),
    .Crc       (w_crc)
  );

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_stream.sv
`default_nettype none
// Bench for eth_rx_stream: an RMII/strip and an MII/pass-through instance
// driven with random frames and checked against a queue scoreboard.
module tb_eth_rx_stream;

  localparam int c_MIN = 64;
  localparam int c_MAX = 1518;

  typedef struct {
    bit     crcErr;
    bit     alignErr;
    bit     lenErr;
    int     len;
    longint doneCyc;
  } status_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        r_crs2, r_crs4;
  logic [1:0]  r_rxd2;
  logic [3:0]  r_rxd4;
  logic        w_v2, w_s2, w_fd2, w_fg2, w_ce2, w_ae2, w_le2;
  logic        w_v4, w_s4, w_fd4, w_fg4, w_ce4, w_ae4, w_le4;
  logic [7:0]  w_d2, w_d4;
  logic [10:0] w_len2, w_len4;

  longint      cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;
  bit          monOn = 1'b0;
  logic [8:0]  byQ2[$], byQ4[$];
  status_t     stQ2[$], stQ4[$];
  logic [7:0]  frm[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  eth_rx_stream #(.pDATA_WIDTH(2), .pSTRIP_FCS(1)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(r_crs2), .Rxd(r_rxd2),
    .Rx_Valid(w_v2), .Rx_Data(w_d2), .Rx_Sof(w_s2), .Frame_Done(w_fd2),
    .Frame_Good(w_fg2), .Crc_Err(w_ce2), .Align_Err(w_ae2), .Len_Err(w_le2),
    .Frame_Len(w_len2));

  eth_rx_stream #(.pDATA_WIDTH(4), .pSTRIP_FCS(0)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(r_crs4), .Rxd(r_rxd4),
    .Rx_Valid(w_v4), .Rx_Data(w_d4), .Rx_Sof(w_s4), .Frame_Done(w_fd4),
    .Frame_Good(w_fg4), .Crc_Err(w_ce4), .Align_Err(w_ae4), .Len_Err(w_le4),
    .Frame_Len(w_len4));

  task automatic chk(input string name, input longint act, input longint exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    nChecks++;
    $display("FAIL %s: got an output event, required none", name);
  endtask

  // FCS as the transmitter computes it: bit-serial LFSR over the first n bytes.
  function automatic logic [31:0] fcsOf(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ frm[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic mon(input int d, input logic v, input logic s, input logic [7:0] dat,
                     input logic fd, input logic fg, input logic ce, input logic ae,
                     input logic le, input logic [10:0] len);
    logic [8:0] eb;
    status_t    st;
    bit         have;
    if (v) begin
      have = (d == 0) ? (byQ2.size() != 0) : (byQ4.size() != 0);
      if (!have) unexpected($sformatf("rx_valid_dut%0d", d));
      else begin
        if (d == 0) eb = byQ2.pop_front(); else eb = byQ4.pop_front();
        chk($sformatf("rx_data_dut%0d", d), longint'(dat), longint'(eb[7:0]));
        chk($sformatf("rx_sof_dut%0d", d), longint'(s), longint'(eb[8]));
      end
    end else begin
      chk($sformatf("sof_idle_dut%0d", d), longint'(s), 0);
    end
    if (fd) begin
      have = (d == 0) ? (stQ2.size() != 0) : (stQ4.size() != 0);
      if (!have) unexpected($sformatf("frame_done_dut%0d", d));
      else begin
        if (d == 0) st = stQ2.pop_front(); else st = stQ4.pop_front();
        chk($sformatf("crc_err_dut%0d", d), longint'(ce), longint'(st.crcErr));
        chk($sformatf("align_err_dut%0d", d), longint'(ae), longint'(st.alignErr));
        chk($sformatf("len_err_dut%0d", d), longint'(le), longint'(st.lenErr));
        chk($sformatf("frame_len_dut%0d", d), longint'(len), longint'(st.len));
        chk($sformatf("frame_good_dut%0d", d), longint'(fg),
            longint'(!(st.crcErr || st.alignErr || st.lenErr)));
        chk($sformatf("done_cycle_dut%0d", d), cyc, st.doneCyc);
      end
    end else begin
      chk($sformatf("status_idle_dut%0d", d), longint'({fg, ce, ae, le, len}), 0);
    end
  endtask

  always @(negedge Clk) begin
    if (monOn) begin
      mon(0, w_v2, w_s2, w_d2, w_fd2, w_fg2, w_ce2, w_ae2, w_le2, w_len2);
      mon(1, w_v4, w_s4, w_d4, w_fd4, w_fg4, w_ce4, w_ae4, w_le4, w_len4);
    end
  end

  task automatic chkAllZero(input string tag);
    chk({tag, "_dut0"}, longint'({w_v2, w_d2, w_s2, w_fd2, w_fg2, w_ce2, w_ae2, w_le2, w_len2}), 0);
    chk({tag, "_dut1"}, longint'({w_v4, w_d4, w_s4, w_fd4, w_fg4, w_ce4, w_ae4, w_le4, w_len4}), 0);
  endtask

  task automatic drive(input int d, input logic crs, input logic [3:0] val);
    if (d == 0) begin r_crs2 = crs; r_rxd2 = val[1:0]; end
    else        begin r_crs4 = crs; r_rxd4 = val;      end
  endtask

  task automatic driveByte(input int d, input logic [7:0] b, input bit rstPulse);
    int beats;
    beats = (d == 0) ? 4 : 2;
    for (int k = 0; k < beats; k++) begin
      @(negedge Clk);
      if (rstPulse && k == 1) begin
        chkAllZero("reset_midframe");
        Rst = 1'b1;
      end
      if (d == 0) drive(d, 1'b1, {2'b00, b[2*k +: 2]});
      else        drive(d, 1'b1, b[4*k +: 4]);
      if (rstPulse && k == 0) Rst = 1'b0;
    end
  endtask

  // nData payload bytes (sequential or random) + correct FCS; optional bit-0
  // flip, trailing partial-byte beats, or a one-cycle reset at byte rstAt.
  task automatic sendFrame(input int d, input int nData, input bit seq,
                           input int flipIdx, input int extra, input int rstAt);
    int          n, nOut, lim;
    logic [31:0] f;
    status_t     st;
    frm.delete();
    for (int i = 0; i < nData; i++) frm.push_back(seq ? 8'(i) : 8'($urandom));
    f = fcsOf(nData);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    n = nData + 4;
    if (flipIdx >= 0) frm[flipIdx][0] = ~frm[flipIdx][0];

    if (rstAt >= 0) nOut = (d == 0) ? ((rstAt > 4) ? rstAt - 4 : 0) : rstAt;
    else begin
      lim  = (n > c_MAX) ? c_MAX : n;
      nOut = (d == 0) ? lim - 4 : lim;
    end
    for (int i = 0; i < nOut; i++) begin
      if (d == 0) byQ2.push_back({i == 0, frm[i]});
      else        byQ4.push_back({i == 0, frm[i]});
    end

    for (int i = 0; i < 7; i++) driveByte(d, 8'h55, 1'b0);
    driveByte(d, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) driveByte(d, frm[i], i == rstAt);
    for (int i = 0; i < extra; i++) begin
      @(negedge Clk);
      drive(d, 1'b1, 4'($urandom));
    end

    @(negedge Clk);
    if (rstAt < 0) begin
      st.crcErr   = fcsOf(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      st.alignErr = (extra != 0);
      st.lenErr   = (n < c_MIN) || (n > c_MAX);
      st.len      = (n > 2047) ? 2047 : n;
      st.doneCyc  = cyc + 3;
      if (d == 0) stQ2.push_back(st); else stQ4.push_back(st);
    end
    drive(d, 1'b0, 4'h0);
    repeat (16) @(negedge Clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nd, fl, ex;
    Rst = 1'b0;
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    repeat (3) @(negedge Clk);
    chkAllZero("reset_state");
    Rst = 1'b1;
    monOn = 1'b1;
    repeat (4) @(negedge Clk);

    sendFrame(0, 60, 1'b1, -1, 0, -1);        // good 64-byte frame
    sendFrame(0, 60, 1'b1, 10, 0, -1);        // byte 10 corrupted
    sendFrame(0, 36, 1'b0, -1, 0, -1);        // runt, 40 bytes
    sendFrame(0, 1596, 1'b0, -1, 0, -1);      // 1600 bytes, over max
    sendFrame(0, 60, 1'b1, -1, 1, -1);        // extra dibit
    sendFrame(1, 60, 1'b1, -1, 0, -1);        // MII, FCS passed through
    sendFrame(1, 60, 1'b0, -1, 1, -1);        // MII, extra nibble
    sendFrame(0, 60, 1'b1, -1, 0, 20);        // reset at byte 20
    sendFrame(0, 60, 1'b0, -1, 0, -1);        // recovery frame

    for (int t = 0; t < 10; t++) begin
      d  = int'($urandom_range(0, 1));
      nd = int'($urandom_range(20, 100));
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nd + 3)) : -1;
      ex = ($urandom_range(0, 3) == 0) ? ((d == 0) ? int'($urandom_range(1, 3)) : 1) : 0;
      sendFrame(d, nd, 1'b0, fl, ex, -1);
    end

    repeat (10) @(negedge Clk);
    chk("bytes_pending_dut0", longint'(byQ2.size()), 0);
    chk("bytes_pending_dut1", longint'(byQ4.size()), 0);
    chk("status_pending_dut0", longint'(stQ2.size()), 0);
    chk("status_pending_dut1", longint'(stQ4.size()), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
